// File: rtl/mem_writer.sv
// mem_writer: loads a depth x width word store either from a ready/valid
// stream or by filling each address with its own index. An independent,
// registered read port returns zero-extended words with 1-cycle latency.
module mem_writer #(
  parameter int A     = 32,
  parameter int width = 4,
  parameter int depth = 16,
  localparam int AW   = $clog2(depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [width-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    wr_ptr,
  input  logic [AW-1:0]    rd_addr,
  output logic [A-1:0]     rd_data
);

  typedef enum logic [1:0] {IDLE, STREAM, FILL, DONE} state_t;

  localparam logic [AW-1:0] LAST    = AW'(depth - 1);
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(depth);

  state_t             state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [A-1:0]       rd_data_q, rd_data_d;
  logic [width-1:0]   mem_q [depth];
  logic               we;
  logic [width-1:0]   wdata;
  logic               at_last;
  logic [AW-1:0]      ptr_next;
  logic               rd_ok;

  assign at_last  = (wr_ptr_q == LAST);
  assign ptr_next = at_last ? '0 : wr_ptr_q + 1'b1;
  // Addresses past the last word (non-power-of-2 depth) read back as zero.
  assign rd_ok    = ({1'b0, rd_addr} < DEPTH_W);

  // Next-state, write strobe and status outputs.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    we       = 1'b0;
    wdata    = in_data;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        // abort outranks start so a simultaneous pair leaves us idle
        if (start && !abort) begin
          wr_ptr_d = '0;
          state_d  = mode ? FILL : STREAM;
        end
      end
      STREAM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (in_valid) begin
          we       = 1'b1;
          wr_ptr_d = ptr_next;
          if (at_last) state_d = DONE;
        end
      end
      FILL: begin
        busy  = 1'b1;
        wdata = width'(wr_ptr_q);
        if (abort) begin
          state_d = IDLE;
        end else begin
          we       = 1'b1;
          wr_ptr_d = ptr_next;
          if (at_last) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read path: old contents on a same-address write, zero when out of range.
  always_comb begin
    rd_data_d = '0;
    if (rd_ok) rd_data_d = A'(mem_q[rd_addr]);
  end

  // Control and read-data registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array: never cleared by reset, write suppressed during reset.
  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[wr_ptr_q] <= wdata;
  end

  assign wr_ptr  = wr_ptr_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_mem_writer.sv
// Directed bench for mem_writer (A=32, width=4, depth=16).
module tb_mem_writer;
  logic        clk = 1'b0;
  logic        rst, start, mode, abort, in_valid;
  logic [3:0]  in_data;
  logic        in_ready, busy, done;
  logic [3:0]  wr_ptr, rd_addr;
  logic [31:0] rd_data;

  int n_chk = 0;
  int n_err = 0;

  mem_writer #(.A(32), .width(4), .depth(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .busy(busy), .done(done), .wr_ptr(wr_ptr), .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input int addr, input logic [31:0] exp);
    rd_addr = 4'(addr);
    tick();
    chk(tag, rd_data, exp);
  endtask

  initial begin
    int busy_cnt, done_cnt, wr_cnt, k, exp_ptr;
    rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; rd_addr = '0;
    tick(); tick();
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_rdy", {31'b0, in_ready}, 0);
    chk("rst_ptr", {28'b0, wr_ptr}, 0);
    chk("rst_rd", rd_data, 0);
    rst = 1'b0;

    // start together with abort in IDLE: stays idle
    start = 1'b1; mode = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", {31'b0, busy}, 0);

    // FILL pass, with a stray start pulse mid-pass
    start = 1'b1; mode = 1'b1;
    tick();
    start = 1'b0;
    chk("fill_rdy", {31'b0, in_ready}, 0);
    busy_cnt = 0; done_cnt = 0; exp_ptr = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) begin
        busy_cnt++;
        chk("fill_ptr", {28'b0, wr_ptr}, 32'(exp_ptr));
        exp_ptr++;
      end
      if (done) done_cnt++;
      start = (i == 5); mode = 1'b0;
      tick();
    end
    start = 1'b0;
    chk("fill_busy_cnt", 32'(busy_cnt), 16);
    chk("fill_done_cnt", 32'(done_cnt), 1);
    chk("fill_ptr_wrap", {28'b0, wr_ptr}, 0);
    for (int a = 0; a < 16; a++) rd_chk("fill_rd", a, 32'(a));

    // Collision: write 0xA to addr 2 while reading addr 2
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    chk("strm_rdy", {31'b0, in_ready}, 1);
    in_valid = 1'b1; in_data = 4'h0; tick();
    in_data = 4'h1; tick();
    in_data = 4'hA; rd_addr = 4'd2; tick();
    chk("coll_old", rd_data, 32'h2);
    in_valid = 1'b0; tick();
    chk("coll_new", rd_data, 32'hA);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("coll_abort_busy", {31'b0, busy}, 0);
    chk("coll_abort_ptr", {28'b0, wr_ptr}, 3);

    // Stream 0xF..0x0 with in_valid toggling
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    k = 0; wr_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid = (c % 2 == 0) && (k < 16);
      in_data  = 4'(15 - k);
      if (done) done_cnt++;
      if (in_valid && in_ready) begin
        k++;
        wr_cnt++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("strm_writes", 32'(wr_cnt), 16);
    chk("strm_done_cnt", 32'(done_cnt), 1);
    chk("strm_busy_end", {31'b0, busy}, 0);
    rd_chk("strm_rd3", 3, 32'hC);
    rd_chk("strm_rd0", 0, 32'hF);
    rd_chk("strm_rd15", 15, 32'h0);

    // Abort after 5 words; abort cycle carries a valid word that must not land
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    done_cnt = 0;
    for (int w = 1; w <= 5; w++) begin
      in_valid = 1'b1; in_data = 4'(w);
      tick();
      if (done) done_cnt++;
    end
    in_data = 4'h7; abort = 1'b1;
    tick();
    if (done) done_cnt++;
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_rdy", {31'b0, in_ready}, 0);
    chk("abort_ptr", {28'b0, wr_ptr}, 5);
    tick();
    if (done) done_cnt++;
    chk("abort_nodone", 32'(done_cnt), 0);
    rd_chk("abort_rd0", 0, 32'h1);
    rd_chk("abort_rd4", 4, 32'h5);
    rd_chk("abort_rd5", 5, 32'hA);

    // Mid-pass reset during FILL at wr_ptr = 7
    start = 1'b1; mode = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (wr_ptr != 4'd7 && k < 30) begin
      tick();
      k++;
    end
    chk("mid_reached7", {28'b0, wr_ptr}, 7);
    rst = 1'b1; rd_addr = 4'd3; start = 1'b1; abort = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    chk("mid_busy", {31'b0, busy}, 0);
    chk("mid_ptr", {28'b0, wr_ptr}, 0);
    chk("mid_rd", rd_data, 0);
    chk("mid_done", {31'b0, done}, 0);
    for (int a = 0; a < 7; a++) rd_chk("mid_keep", a, 32'(a));
    rd_chk("mid_rd7", 7, 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
